// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with synchronised columns,
// per-scan multi-key rejection and scan-level debouncing.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] num,
    output logic       numPressed,
    output logic       clear,
    output logic       submit
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(SCAN_DIV - 1);
    localparam logic [3:0] DEB    = 4'(DEBOUNCE);
    localparam logic [3:0] DEB_M1 = 4'(DEBOUNCE - 1);
    localparam logic       DEB_ONE = (DEBOUNCE == 1);

    localparam logic [3:0] K_CLR  = 4'd10;
    localparam logic [3:0] K_SUB  = 4'd11;
    localparam logic [3:0] K_NONE = 4'd15;

    typedef enum logic [1:0] {
        S_ROW0 = 2'd0,
        S_ROW1 = 2'd1,
        S_ROW2 = 2'd2,
        S_ROW3 = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [TW-1:0] r_timer;
    logic          w_win_end;
    logic          w_scan_end;

    logic [3:0]    r_col_s1;
    logic [3:0]    r_col_s2;

    logic [1:0]    r_acc_cnt;
    logic [3:0]    r_acc_key;
    logic [1:0]    w_row_cnt;
    logic [3:0]    w_row_key;
    logic [2:0]    w_sum;
    logic [1:0]    w_tot_cnt;
    logic [3:0]    w_tot_key;
    logic [3:0]    w_scan_key;

    logic [3:0]    r_cand;
    logic [3:0]    r_stable;
    logic          r_accept;

    logic          w_is_digit;
    logic          w_is_clr;
    logic          w_is_sub;

    function automatic logic [3:0] key_map(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] k;
        unique case ({r, c})
            4'b00_00: k = 4'd1;
            4'b00_01: k = 4'd2;
            4'b00_10: k = 4'd3;
            4'b00_11: k = K_CLR;
            4'b01_00: k = 4'd4;
            4'b01_01: k = 4'd5;
            4'b01_10: k = 4'd6;
            4'b10_00: k = 4'd7;
            4'b10_01: k = 4'd8;
            4'b10_10: k = 4'd9;
            4'b11_01: k = 4'd0;
            4'b11_10: k = K_SUB;
            default:  k = K_NONE;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col_s1 <= 4'b1111;
            r_col_s2 <= 4'b1111;
        end else begin
            r_col_s1 <= col;
            r_col_s2 <= r_col_s1;
        end
    end

    assign w_win_end  = (r_timer == T_LAST);
    assign w_scan_end = w_win_end && (r_state == S_ROW3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_win_end) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_ROW0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_win_end) begin
            unique case (r_state)
                S_ROW0: w_state_next = S_ROW1;
                S_ROW1: w_state_next = S_ROW2;
                S_ROW2: w_state_next = S_ROW3;
                S_ROW3: w_state_next = S_ROW0;
            endcase
        end
    end

    always_comb begin
        row = 4'b1111;
        unique case (r_state)
            S_ROW0: row = 4'b1110;
            S_ROW1: row = 4'b1101;
            S_ROW2: row = 4'b1011;
            S_ROW3: row = 4'b0111;
        endcase
    end

    // Mapped keys seen low in the current row, count saturates at 2.
    always_comb begin
        w_row_cnt = 2'd0;
        w_row_key = K_NONE;
        for (int c = 0; c < 4; c++) begin
            if (key_map(r_state, 2'(c)) != K_NONE && !r_col_s2[c]) begin
                if (w_row_cnt == 2'd0) begin
                    w_row_key = key_map(r_state, 2'(c));
                end
                if (w_row_cnt != 2'd2) begin
                    w_row_cnt = w_row_cnt + 2'd1;
                end
            end
        end
    end

    assign w_sum      = {1'b0, r_acc_cnt} + {1'b0, w_row_cnt};
    assign w_tot_cnt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_tot_key  = (r_acc_cnt == 2'd0) ? w_row_key : r_acc_key;
    assign w_scan_key = (w_tot_cnt == 2'd1) ? w_tot_key : K_NONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_cnt <= 2'd0;
            r_acc_key <= K_NONE;
        end else if (w_scan_end) begin
            r_acc_cnt <= 2'd0;
            r_acc_key <= K_NONE;
        end else if (w_win_end) begin
            r_acc_cnt <= w_tot_cnt;
            r_acc_key <= w_tot_key;
        end
    end

    // r_accept marks the one scan where the count first reaches DEBOUNCE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cand   <= K_NONE;
            r_stable <= DEB;
            r_accept <= 1'b0;
        end else if (w_scan_end) begin
            if (w_scan_key == r_cand) begin
                if (r_stable != DEB) begin
                    r_stable <= r_stable + 4'd1;
                end
                r_accept <= (r_stable == DEB_M1);
            end else begin
                r_cand   <= w_scan_key;
                r_stable <= 4'd1;
                r_accept <= DEB_ONE;
            end
        end else begin
            r_accept <= 1'b0;
        end
    end

    assign w_is_digit = (r_cand <= 4'd9);
    assign w_is_clr   = (r_cand == K_CLR);
    assign w_is_sub   = (r_cand == K_SUB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num        <= 4'd0;
            numPressed <= 1'b0;
            clear      <= 1'b0;
            submit     <= 1'b0;
        end else if (r_accept) begin
            unique case (1'b1)
                w_is_digit: begin
                    num        <= r_cand;
                    numPressed <= 1'b1;
                    clear      <= 1'b0;
                    submit     <= 1'b0;
                end
                w_is_clr: begin
                    numPressed <= 1'b0;
                    clear      <= 1'b1;
                    submit     <= 1'b0;
                end
                w_is_sub: begin
                    numPressed <= 1'b0;
                    clear      <= 1'b0;
                    submit     <= 1'b1;
                end
                default: begin
                    numPressed <= 1'b0;
                    clear      <= 1'b0;
                    submit     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles each row is driven; legal range 4..65535.
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive identical full scans required to accept a key state; legal range 1..15.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port col  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port row  output  4  keypad row drive, active-low one-hot.
REQ-007 SHALL have port num  output  4  binary value of the last accepted digit key.
REQ-008 SHALL have port numPressed  output  1  level, high while an accepted digit key is held.
REQ-009 SHALL have port clear  output  1  level, high while the accepted CLR key is held.
REQ-010 SHALL have port submit  output  1  level, high while the accepted SUB key is held.

Function
REQ-011 SHALL pass col through a 2-flop synchroniser; only synchronised values are used.
REQ-012 SHALL drive rows in order 0,1,2,3,0,...; row k low for exactly SCAN_DIV cycles, others high; one full scan = 4*SCAN_DIV cycles.
REQ-013 SHALL sample the synchronised col on the last cycle of each row window.
REQ-014 SHALL map (row,col) to keys: row0 = 1,2,3,CLR; row1 = 4,5,6,none; row2 = 7,8,9,none; row3 = none,0,SUB,none; "none" positions are ignored.
REQ-015 SHALL form one scan result per full scan: NOKEY if no mapped key is low; the key if exactly one mapped key is low; NOKEY if two or more mapped keys are low (multi-key rejection).
REQ-016 SHALL, at the end of each full scan, compare the result with a held candidate: if equal, increment the stable count, saturating at DEBOUNCE; if different, load candidate with the result and set count to 1.
REQ-017 SHALL update outputs on the clock after the scan in which the count first reaches DEBOUNCE; outputs are registered and otherwise hold.
REQ-018 SHALL, on acceptance of a digit d: numPressed=1, num=d, clear=0, submit=0.
REQ-019 SHALL, on acceptance of CLR: clear=1, numPressed=0, submit=0, num unchanged.
REQ-020 SHALL, on acceptance of SUB: submit=1, numPressed=0, clear=0, num unchanged.
REQ-021 SHALL, on acceptance of NOKEY: numPressed=clear=submit=0, num unchanged.
REQ-022 SHALL keep numPressed, clear and submit mutually exclusive in every cycle.
REQ-023 SHALL give a direct change from one held key to another (no release seen) a single output update, with no intermediate all-zero cycle.
REQ-024 SHALL give key bounce shorter than DEBOUNCE full scans no output change.
REQ-025 SHALL make acceptance latency DEBOUNCE full scans after the first full scan that sees the new state, plus 1 cycle.

Reset
REQ-026 SHALL, while reset is low, force row=4'b1110 (row0 driven), num=0, numPressed=0, clear=0, submit=0, candidate=NOKEY, stable count=DEBOUNCE, row timer=0, synchroniser flops=4'b1111.
REQ-027 SHALL, after reset deasserts, start a fresh row-0 window on the next rising edge; a partial scan interrupted by reset is discarded.

Verification
(bench: SCAN_DIV=4, DEBOUNCE=2, scan = 16 cycles; a key model pulls col low while its row is driven.)
REQ-028 SHALL cover: hold key '5' from scan boundary -> numPressed=1, num=5 one cycle after the 2nd full scan (cycle 33); clear=submit=0.
REQ-029 SHALL cover: release '5' -> numPressed=0 one cycle after 2 consecutive NOKEY scans; num stays 5.
REQ-030 SHALL cover: press CLR, then SUB, each held 4 scans -> clear pulse-level high, then submit high; never both high; num unchanged.
REQ-031 SHALL cover: '8' low for only 1 scan, then released -> no output change.
REQ-032 SHALL cover: '1' and '9' held together for 4 scans -> outputs remain NOKEY state; release '9' with '1' held -> num=1, numPressed=1 after 2 scans.
REQ-033 SHALL cover: assert reset mid-scan with '7' held and accepted -> outputs and row return to reset values immediately; after release, '7' is re-accepted after 2 full scans.
